// File: rtl/rrv64_tcm_axi_slv_bridge.sv
// AXI4 slave front end of the TCM port: serialises each AR/AW burst beat into one
// TCM request and returns TCM data/errors as AXI R/B responses, one beat at a time.
module rrv64_tcm_axi_slv_bridge #(
  parameter int OUT_UNCORE_AXI_S_TCM_RADDR_WIDTH = 32,
  parameter int OUT_UNCORE_AXI_S_TCM_RID_WIDTH   = 4,
  parameter int OUT_UNCORE_AXI_S_TCM_WDATA_WIDTH = 64,
  parameter int ADDR_W = OUT_UNCORE_AXI_S_TCM_RADDR_WIDTH,
  parameter int ID_W   = OUT_UNCORE_AXI_S_TCM_RID_WIDTH,
  parameter int DATA_W = OUT_UNCORE_AXI_S_TCM_WDATA_WIDTH,
  localparam int STRB_W = DATA_W / 8,
  localparam int AX_W   = ID_W + ADDR_W + 13,
  localparam int W_W    = ID_W + DATA_W + STRB_W + 1,
  localparam int R_W    = ID_W + DATA_W + 3,
  localparam int B_W    = ID_W + 2,
  localparam int REQ_W  = ID_W + 1 + ADDR_W + DATA_W,
  localparam int RSP_W  = ID_W + DATA_W + 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ar_valid,
  output logic             ar_ready,
  input  logic [AX_W-1:0]  ar,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [R_W-1:0]   r,
  input  logic             aw_valid,
  output logic             aw_ready,
  input  logic [AX_W-1:0]  aw,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [W_W-1:0]   w,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [B_W-1:0]   b,
  output logic             tcm_req_valid,
  input  logic             tcm_req_ready,
  output logic [REQ_W-1:0] tcm_req,
  input  logic             tcm_resp_valid,
  output logic             tcm_resp_ready,
  input  logic [RSP_W-1:0] tcm_resp
);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ax_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_t;

  typedef struct packed {
    logic [ID_W-1:0]   trans_id;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [ID_W-1:0]   trans_id;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        error;
  } rsp_t;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, RD_DATA, WR_DATA, WR_REQ, WR_WAIT, WR_RESP
  } state_e;

  ax_t  ar_s, aw_s;
  w_t   w_s;
  rsp_t rsp_s;
  r_t   r_s;
  b_t   b_s;
  req_t req_s;

  assign ar_s  = ar;
  assign aw_s  = aw;
  assign w_s   = w;
  assign rsp_s = tcm_resp;
  assign r       = r_s;
  assign b       = b_s;
  assign tcm_req = req_s;

  // wid, wlast and the response trans_id play no part in sequencing
  logic unused_ok;
  assign unused_ok = ^{w_s.id, w_s.last, rsp_s.trans_id};

  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [7:0]        beat_q, beat_d;
  logic [1:0]        err_q, err_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              last_beat;
  logic              bad_burst;
  logic [ADDR_W-1:0] next_addr;

  assign last_beat = (beat_q == len_q);
  // WRAP and the reserved encoding share burst[1]; neither reaches the TCM
  assign bad_burst = burst_q[1];
  assign next_addr = (burst_q == 2'b01) ? addr_q + (ADDR_W'(1) << size_q) : addr_q;

  always_comb begin
    state_d        = state_q;
    rr_last_d      = rr_last_q;
    beat_d         = beat_q;
    err_d          = err_q;
    id_d           = id_q;
    addr_d         = addr_q;
    len_d          = len_q;
    size_d         = size_q;
    burst_d        = burst_q;
    rdata_d        = rdata_q;
    rresp_d        = rresp_q;
    wdata_d        = wdata_q;
    ar_ready       = 1'b0;
    aw_ready       = 1'b0;
    w_ready        = 1'b0;
    r_valid        = 1'b0;
    b_valid        = 1'b0;
    tcm_req_valid  = 1'b0;
    tcm_resp_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        // rr_last_q=1 means the previous grant went to the read side
        if (rstn && ar_valid && !(aw_valid && rr_last_q)) begin
          ar_ready  = 1'b1;
          rr_last_d = 1'b1;
          id_d      = ar_s.id;
          addr_d    = ar_s.addr;
          len_d     = ar_s.len;
          size_d    = ar_s.size;
          burst_d   = ar_s.burst;
          beat_d    = 8'd0;
          err_d     = 2'b00;
          state_d   = RD_REQ;
        end else if (rstn && aw_valid) begin
          aw_ready  = 1'b1;
          rr_last_d = 1'b0;
          id_d      = aw_s.id;
          addr_d    = aw_s.addr;
          len_d     = aw_s.len;
          size_d    = aw_s.size;
          burst_d   = aw_s.burst;
          beat_d    = 8'd0;
          err_d     = 2'b00;
          state_d   = WR_DATA;
        end
      end
      RD_REQ: begin
        if (bad_burst) begin
          rdata_d = '0;
          rresp_d = 2'b10;
          state_d = RD_DATA;
        end else begin
          tcm_req_valid = 1'b1;
          if (tcm_req_ready) state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        tcm_resp_ready = 1'b1;
        if (tcm_resp_valid) begin
          rdata_d = rsp_s.rdata;
          rresp_d = rsp_s.error;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        r_valid = 1'b1;
        if (r_ready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d  = next_addr;
            beat_d  = beat_q + 8'd1;
            state_d = RD_REQ;
          end
        end
      end
      WR_DATA: begin
        w_ready = 1'b1;
        if (w_valid) begin
          wdata_d = w_s.data;
          if (&w_s.strb && !bad_burst) begin
            state_d = WR_REQ;
          end else begin
            err_d = 2'b10;
            if (last_beat) begin
              state_d = WR_RESP;
            end else begin
              addr_d = next_addr;
              beat_d = beat_q + 8'd1;
            end
          end
        end
      end
      WR_REQ: begin
        tcm_req_valid = 1'b1;
        if (tcm_req_ready) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        tcm_resp_ready = 1'b1;
        if (tcm_resp_valid) begin
          if (rsp_s.error > err_q) err_d = rsp_s.error;
          if (last_beat) begin
            state_d = WR_RESP;
          end else begin
            addr_d  = next_addr;
            beat_d  = beat_q + 8'd1;
            state_d = WR_DATA;
          end
        end
      end
      WR_RESP: begin
        b_valid = 1'b1;
        if (b_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Payloads are driven only in the states that present them, so reset zeroes them
  always_comb begin
    r_s   = '0;
    b_s   = '0;
    req_s = '0;
    if (state_q == RD_DATA) begin
      r_s.id   = id_q;
      r_s.data = rdata_q;
      r_s.resp = rresp_q;
      r_s.last = last_beat;
    end
    if (state_q == WR_RESP) begin
      b_s.id   = id_q;
      b_s.resp = err_q;
    end
    if ((state_q == RD_REQ && !bad_burst) || state_q == WR_REQ) begin
      req_s.trans_id = id_q;
      req_s.wren     = (state_q == WR_REQ);
      req_s.addr     = addr_q;
      req_s.wdata    = (state_q == WR_REQ) ? wdata_q : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b0;
      beat_q    <= 8'd0;
      err_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    id_q    <= id_d;
    addr_q  <= addr_d;
    len_q   <= len_d;
    size_q  <= size_d;
    burst_q <= burst_d;
    rdata_q <= rdata_d;
    rresp_q <= rresp_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_rrv64_tcm_axi_slv_bridge.sv
// Directed bench for rrv64_tcm_axi_slv_bridge: reads, writes, strobe and burst errors,
// round-robin arbitration and asynchronous reset, checked with immediate assertions.
module tb_rrv64_tcm_axi_slv_bridge;

  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ax_t;
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_t;
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_t;
  typedef struct packed {
    logic [ID_W-1:0]   trans_id;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;
  typedef struct packed {
    logic [ID_W-1:0]   trans_id;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        error;
  } rsp_t;

  logic clk = 1'b0;
  logic rstn;
  logic ar_valid, ar_ready, r_valid, r_ready, aw_valid, aw_ready;
  logic w_valid, w_ready, b_valid, b_ready;
  logic tcm_req_valid, tcm_req_ready, tcm_resp_valid, tcm_resp_ready;
  ax_t  ar_s, aw_s;
  w_t   w_s;
  r_t   r_s;
  b_t   b_s;
  req_t req_s;
  rsp_t rsp_s;

  int n_chk = 0;
  int n_err = 0;
  int n_req = 0;
  int base;

  always #5 clk = ~clk;

  rrv64_tcm_axi_slv_bridge #(
    .OUT_UNCORE_AXI_S_TCM_RADDR_WIDTH(ADDR_W),
    .OUT_UNCORE_AXI_S_TCM_RID_WIDTH  (ID_W),
    .OUT_UNCORE_AXI_S_TCM_WDATA_WIDTH(DATA_W)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .ar_valid      (ar_valid),
    .ar_ready      (ar_ready),
    .ar            (ar_s),
    .r_valid       (r_valid),
    .r_ready       (r_ready),
    .r             (r_s),
    .aw_valid      (aw_valid),
    .aw_ready      (aw_ready),
    .aw            (aw_s),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w             (w_s),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .b             (b_s),
    .tcm_req_valid (tcm_req_valid),
    .tcm_req_ready (tcm_req_ready),
    .tcm_req       (req_s),
    .tcm_resp_valid(tcm_resp_valid),
    .tcm_resp_ready(tcm_resp_ready),
    .tcm_resp      (rsp_s)
  );

  always @(posedge clk) if (tcm_req_valid && tcm_req_ready) n_req <= n_req + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    ar_s = '{id: id, addr: addr, len: len, size: 3'd3, burst: burst};
    ar_valid = 1'b1;
    #1;
    while (!ar_ready && n < 40) begin tick(); n++; end
    chk("ar_ready", ar_ready, 1'b1);
    tick();
    ar_valid = 1'b0;
  endtask

  task automatic send_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    aw_s = '{id: id, addr: addr, len: len, size: 3'd3, burst: burst};
    aw_valid = 1'b1;
    #1;
    while (!aw_ready && n < 40) begin tick(); n++; end
    chk("aw_ready", aw_ready, 1'b1);
    tick();
    aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb);
    int n = 0;
    w_s = '{id: '0, data: data, strb: strb, last: 1'b1};
    w_valid = 1'b1;
    #1;
    while (!w_ready && n < 40) begin tick(); n++; end
    chk("w_ready", w_ready, 1'b1);
    tick();
    w_valid = 1'b0;
  endtask

  // Accepts one TCM request, checks it, and answers with the given data/error
  task automatic serve(input string tag, input logic wren, input logic [ADDR_W-1:0] addr,
                       input logic [ID_W-1:0] id, input logic [DATA_W-1:0] wdata,
                       input logic [DATA_W-1:0] rdata, input logic [1:0] err);
    int n = 0;
    req_t e;
    while (!tcm_req_valid && n < 40) begin tick(); n++; end
    chk({tag, "_req_valid"}, tcm_req_valid, 1'b1);
    e = '{trans_id: id, wren: wren, addr: addr, wdata: wdata};
    chk({tag, "_req"}, req_s, e);
    tcm_req_ready = 1'b1;
    tick();
    tcm_req_ready = 1'b0;
    chk({tag, "_req_dropped"}, tcm_req_valid, 1'b0);
    rsp_s = '{trans_id: id, rdata: rdata, error: err};
    tcm_resp_valid = 1'b1;
    #1;
    chk({tag, "_resp_ready"}, tcm_resp_ready, 1'b1);
    tick();
    tcm_resp_valid = 1'b0;
  endtask

  task automatic recv_r(input string tag, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data,
                        input logic [1:0] resp, input logic last, input bit stall);
    int n = 0;
    r_t e;
    e = '{id: id, data: data, resp: resp, last: last};
    while (!r_valid && n < 40) begin tick(); n++; end
    chk({tag, "_r_valid"}, r_valid, 1'b1);
    chk({tag, "_r"}, r_s, e);
    if (stall) begin
      repeat (2) begin
        tick();
        chk({tag, "_r_hold_valid"}, r_valid, 1'b1);
        chk({tag, "_r_hold"}, r_s, e);
      end
    end
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
  endtask

  task automatic recv_b(input string tag, input logic [ID_W-1:0] id, input logic [1:0] resp);
    int n = 0;
    b_t e;
    e = '{id: id, resp: resp};
    while (!b_valid && n < 40) begin tick(); n++; end
    chk({tag, "_b_valid"}, b_valid, 1'b1);
    chk({tag, "_b"}, b_s, e);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    ar_valid = 0; aw_valid = 0; w_valid = 0; r_ready = 0; b_ready = 0;
    tcm_req_ready = 0; tcm_resp_valid = 0;
    ar_s = '0; aw_s = '0; w_s = '0; rsp_s = '0;
    repeat (3) tick();
    // Reset state, with requests presented so the grant must stay off
    ar_valid = 1'b1; aw_valid = 1'b1;
    #1;
    chk("rst_ar_ready", ar_ready, 1'b0);
    chk("rst_aw_ready", aw_ready, 1'b0);
    chk("rst_tcm_req_valid", tcm_req_valid, 1'b0);
    chk("rst_tcm_resp_ready", tcm_resp_ready, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_payloads", {r_s, b_s, req_s}, '0);
    ar_valid = 1'b0; aw_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // Single read against a zero-wait TCM
    tcm_req_ready = 1'b1;
    tcm_resp_valid = 1'b1;
    rsp_s = '{trans_id: 4'd5, rdata: 64'hDEAD_BEEF, error: 2'b00};
    base = n_req;
    send_ar(4'd5, 32'h100, 8'd0, 2'b01);
    chk("single_req_valid_n1", tcm_req_valid, 1'b1);
    chk("single_req", req_s, {4'd5, 1'b0, 32'h100, 64'h0});
    chk("single_r_valid_n1", r_valid, 1'b0);
    tick();
    chk("single_r_valid_n2", r_valid, 1'b0);
    tick();
    chk("single_r_valid_n3", r_valid, 1'b1);
    tcm_req_ready = 1'b0;
    tcm_resp_valid = 1'b0;
    recv_r("single", 4'd5, 64'hDEAD_BEEF, 2'b00, 1'b1, 1'b0);
    chk("single_req_count", n_req - base, 1);

    // INCR read burst with R backpressure on alternate beats
    base = n_req;
    send_ar(4'd2, 32'h1F8, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      serve("incr", 1'b0, 32'h1F8 + 32'(8 * i), 4'd2, 64'h0, 64'h1000 + 64'(i), 2'b00);
      recv_r("incr", 4'd2, 64'h1000 + 64'(i), 2'b00, i == 3, (i % 2) == 0);
    end
    chk("incr_req_count", n_req - base, 4);

    // FIXED write burst, second beat returns SLVERR
    base = n_req;
    send_aw(4'd7, 32'h40, 8'd1, 2'b00);
    send_w(64'hAAAA_0000_1111_2222, 8'hFF);
    serve("wfix0", 1'b1, 32'h40, 4'd7, 64'hAAAA_0000_1111_2222, 64'h0, 2'b00);
    send_w(64'h5555_3333_4444_6666, 8'hFF);
    serve("wfix1", 1'b1, 32'h40, 4'd7, 64'h5555_3333_4444_6666, 64'h0, 2'b10);
    recv_b("wfix", 4'd7, 2'b10);
    chk("wfix_req_count", n_req - base, 2);

    // Partial strobe skips the TCM
    base = n_req;
    send_aw(4'd3, 32'h80, 8'd0, 2'b01);
    send_w(64'h1234, 8'h0F);
    recv_b("wstrb", 4'd3, 2'b10);
    chk("wstrb_req_count", n_req - base, 0);

    // Arbitration from a fresh reset
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    ar_s = '{id: 4'd1, addr: 32'h10, len: 8'd0, size: 3'd3, burst: 2'b01};
    aw_s = '{id: 4'd2, addr: 32'h20, len: 8'd0, size: 3'd3, burst: 2'b01};
    ar_valid = 1'b1; aw_valid = 1'b1;
    #1;
    chk("arb1_ar_ready", ar_ready, 1'b1);
    chk("arb1_aw_ready", aw_ready, 1'b0);
    tick();
    ar_valid = 1'b0;
    serve("arb_rd1", 1'b0, 32'h10, 4'd1, 64'h0, 64'h11, 2'b00);
    ar_s = '{id: 4'd4, addr: 32'h30, len: 8'd0, size: 3'd3, burst: 2'b01};
    ar_valid = 1'b1;
    recv_r("arb_rd1", 4'd1, 64'h11, 2'b00, 1'b1, 1'b0);
    chk("arb2_aw_ready", aw_ready, 1'b1);
    chk("arb2_ar_ready", ar_ready, 1'b0);
    tick();
    aw_valid = 1'b0;
    send_w(64'h22, 8'hFF);
    serve("arb_wr1", 1'b1, 32'h20, 4'd2, 64'h22, 64'h0, 2'b00);
    aw_s = '{id: 4'd6, addr: 32'h60, len: 8'd0, size: 3'd3, burst: 2'b01};
    aw_valid = 1'b1;
    recv_b("arb_wr1", 4'd2, 2'b00);
    chk("arb3_ar_ready", ar_ready, 1'b1);
    chk("arb3_aw_ready", aw_ready, 1'b0);
    tick();
    ar_valid = 1'b0;
    serve("arb_rd2", 1'b0, 32'h30, 4'd4, 64'h0, 64'h33, 2'b00);
    recv_r("arb_rd2", 4'd4, 64'h33, 2'b00, 1'b1, 1'b0);
    chk("arb4_aw_ready", aw_ready, 1'b1);
    tick();
    aw_valid = 1'b0;
    send_w(64'h66, 8'hFF);
    serve("arb_wr2", 1'b1, 32'h60, 4'd6, 64'h66, 64'h0, 2'b00);
    recv_b("arb_wr2", 4'd6, 2'b00);

    // WRAP read never reaches the TCM
    base = n_req;
    send_ar(4'd9, 32'h200, 8'd1, 2'b10);
    recv_r("wrap0", 4'd9, 64'h0, 2'b10, 1'b0, 1'b0);
    recv_r("wrap1", 4'd9, 64'h0, 2'b10, 1'b1, 1'b0);
    chk("wrap_req_count", n_req - base, 0);

    // Asynchronous reset while waiting on the TCM
    send_ar(4'd3, 32'h300, 8'd3, 2'b01);
    chk("rstmid_req_valid", tcm_req_valid, 1'b1);
    tcm_req_ready = 1'b1;
    tick();
    tcm_req_ready = 1'b0;
    chk("rstmid_in_wait", tcm_resp_ready, 1'b1);
    #1;
    rstn = 1'b0;
    #1;
    chk("rstmid_resp_ready", tcm_resp_ready, 1'b0);
    chk("rstmid_req_valid0", tcm_req_valid, 1'b0);
    chk("rstmid_valids", {r_valid, b_valid, ar_ready, aw_ready, w_ready}, 5'b0);
    chk("rstmid_payloads", {r_s, b_s, req_s}, '0);
    tick();
    rstn = 1'b1;
    rsp_s = '{trans_id: 4'd3, rdata: 64'hBAD, error: 2'b00};
    tcm_resp_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("rstmid_no_r", {r_valid, tcm_req_valid, tcm_resp_ready}, 3'b0);
    end
    tcm_resp_valid = 1'b0;
    send_ar(4'd1, 32'h8, 8'd0, 2'b01);
    serve("post_rst", 1'b0, 32'h8, 4'd1, 64'h0, 64'h77, 2'b00);
    recv_r("post_rst", 4'd1, 64'h77, 2'b00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
